data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, the number of 32-bit words in the array (power of 2).
REQ-002 SHALL have parameter LATENCY, default 2, the wait cycles between request accept and response (0..15).
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, CPU request present.
REQ-006 SHALL have port req_ready, output, 1, responder can accept a request.
REQ-007 SHALL have port req_write, input, 1, 1=store, 0=load.
REQ-008 SHALL have port req_size, input, 2, 00=byte, 01=half, 10=word, 11=reserved.
REQ-009 SHALL have port req_addr, input, 32, byte address.
REQ-010 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1, response present.
REQ-012 SHALL have port resp_ready, input, 1, CPU consumes the response.
REQ-013 SHALL have port resp_rdata, output, 32, load data, right-aligned and zero-extended; 0 for stores.
REQ-014 SHALL have port resp_err, output, 1, access error flag, valid with resp_valid.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted on a rising edge with req_valid&&req_ready, latching write, size, addr and wdata.
REQ-017 SHALL go IDLE->WAIT on accept, loading a wait counter with LATENCY; with LATENCY=0, go IDLE->RESP directly.
REQ-018 SHALL decrement the counter each WAIT cycle and go WAIT->RESP on the edge where it reaches 0; resp_valid rises exactly LATENCY+1 edges after the accept edge.
REQ-019 SHALL perform the store and capture the load data on the edge that enters RESP, not earlier.
REQ-020 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until an edge with resp_ready=1, then go to IDLE.
REQ-021 SHALL ignore resp_ready outside RESP; a resp_ready already high when RESP is entered completes the response on the next edge.
REQ-022 SHALL NOT accept back-to-back requests; at least one IDLE cycle with req_ready=1 separates two responses.
REQ-023 SHALL use little-endian byte lanes: word index = addr[31:2] mod DEPTH_WORDS (wrap-around, no error); the byte lane is addr[1:0] and the half lane is addr[1].
REQ-024 SHALL, for byte and half stores, modify only the addressed lanes and preserve all other bytes.
REQ-025 SHALL treat req_size=11 as word when REQ-034 is inactive.

Reset
REQ-026 SHALL, on reset assertion, immediately force state=IDLE, counter=0, req_ready=0 while reset is asserted, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-027 SHALL abort any in-flight request on reset: no store is performed, and no response is issued afterward.
REQ-028 SHALL NOT clear the memory array contents on reset.
REQ-029 SHALL drive req_ready=1 on the first rising edge after reset deasserts.

Configuration
REQ-030 SHALL compile the alignment check only when macro DMEM_ALIGN_CHECK_EN is defined.
REQ-031 With DMEM_ALIGN_CHECK_EN defined, resp_err SHALL be 1 for a half with addr[0]=1, a word with addr[1:0]!=0, or size=11.
REQ-032 With DMEM_ALIGN_CHECK_EN defined, an erroring store SHALL write nothing, and an erroring load SHALL return resp_rdata=0.
REQ-033 With DMEM_ALIGN_CHECK_EN defined, response timing SHALL be unchanged by an error.
REQ-034 Without DMEM_ALIGN_CHECK_EN, resp_err SHALL be tied 0, misaligned addresses SHALL be aligned down (half: addr[0] cleared; word: addr[1:0] cleared), and REQ-025 applies.

Verification
REQ-035 Word store then load, LATENCY=2: store 0xDEADBEEF @0x10; load @0x10 -> resp_rdata=0xDEADBEEF; resp_valid is 3 edges after each accept.
REQ-036 Byte merge: word 0x11223344 @0x20; store byte 0xAA @0x22; word load @0x20 -> 0x11AA3344; byte load @0x23 -> 0x00000011.
REQ-037 Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stay stable and req_ready=0; release -> IDLE next edge.
REQ-038 Reset mid-WAIT: store 0x55 @0x30 (prior 0); assert reset in the WAIT state -> outputs zero immediately, no response; reload @0x30 -> 0.
REQ-039 Wrap: DEPTH_WORDS=256; store 0x1234 @0x400 -> load @0x0 returns 0x00001234.
REQ-040 With DMEM_ALIGN_CHECK_EN: word load @0x02 -> resp_err=1 and rdata=0; without it -> resp_err=0 and data from word @0x00.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-ported 32-bit data memory behind a valid/ready request channel
// and a valid/ready response channel. Each request is accepted, held for LATENCY wait
// cycles, then served: the store or load happens on the edge that enters the response
// state, and the response is held until the CPU takes it.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two); word index wraps modulo depth
//   LATENCY      wait cycles between accept and response (0..15)
//
// Ports:
//   clock, reset                 single clock, asynchronous active-high reset
//   req_valid / req_ready        request handshake (ready only while idle)
//   req_write, req_size          1=store/0=load; 00 byte, 01 half, 10 word, 11 reserved
//   req_addr, req_wdata          byte address, right-aligned store data
//   resp_valid / resp_ready      response handshake
//   resp_rdata, resp_err         right-aligned zero-extended load data (0 for stores), error
//
// Build option:
//   DMEM_ALIGN_CHECK_EN  when defined, misaligned half/word accesses and size 11 report
//                        resp_err, write nothing and return 0. When undefined, resp_err is
//                        0, misaligned addresses are aligned down and size 11 acts as word.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IdxW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LatInit = LATENCY[3:0];

    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;
    localparam logic [1:0] SzWord = 2'b10;
    localparam logic [1:0] SzRsvd = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    // Fields of the access being performed. With LATENCY=0 the access happens on the
    // accept edge itself, so the live request is used instead of the latched copy.
    logic        acc_write;
    logic [1:0]  acc_size;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;

    logic        accept;
    logic        do_access;
    logic        acc_err;
    logic [1:0]  eff_size;
    logic [1:0]  lane;
    logic [4:0]  lane_sh;
    logic [3:0]  be_base;
    logic [3:0]  be;
    logic [31:0] size_mask;
    logic [31:0] wdata_al;
    logic [IdxW-1:0] idx;
    logic [31:0] rd_word;
    logic [31:0] load_data;
    logic [31:0] resp_data_next;
    logic        unused_addr;

    assign req_ready  = (state_q == StIdle) && !reset;
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    assign accept = req_valid && req_ready;

    always_comb begin
        if (state_q == StIdle) begin
            acc_write = req_write;
            acc_size  = req_size;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end else begin
            acc_write = write_q;
            acc_size  = size_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

    // Size/alignment decode and lane selection.
    always_comb begin
        acc_err  = 1'b0;
        eff_size = acc_size;
`ifdef DMEM_ALIGN_CHECK_EN
        unique case (acc_size)
            SzHalf:  acc_err = acc_addr[0];
            SzWord:  acc_err = |acc_addr[1:0];
            SzRsvd:  acc_err = 1'b1;
            default: acc_err = 1'b0;
        endcase
`else
        if (acc_size == SzRsvd) begin
            eff_size = SzWord;
        end
`endif
        lane      = 2'b00;
        be_base   = 4'b1111;
        size_mask = 32'hFFFF_FFFF;
        unique case (eff_size)
            SzByte: begin
                lane      = acc_addr[1:0];
                be_base   = 4'b0001;
                size_mask = 32'h0000_00FF;
            end
            SzHalf: begin
                lane      = {acc_addr[1], 1'b0};
                be_base   = 4'b0011;
                size_mask = 32'h0000_FFFF;
            end
            default: begin
                lane      = 2'b00;
                be_base   = 4'b1111;
                size_mask = 32'hFFFF_FFFF;
            end
        endcase
    end

    assign lane_sh   = {lane, 3'b000};
    assign be        = be_base << lane;
    assign wdata_al  = acc_wdata << lane_sh;
    assign idx       = acc_addr[IdxW+1:2];
    assign rd_word   = mem[idx];
    assign load_data = (rd_word >> lane_sh) & size_mask;

    // Upper address bits beyond the array are intentionally ignored (wrap-around).
    assign unused_addr = ^acc_addr[31:IdxW+2];

    assign resp_data_next = (acc_write || acc_err) ? 32'h0 : load_data;

    // The edge that enters the response state is the only one that touches the array.
    always_comb begin
        do_access = 1'b0;
        if (state_q == StWait && cnt_q == 4'd0) begin
            do_access = 1'b1;
        end else if (state_q == StIdle && accept && LATENCY == 0) begin
            do_access = 1'b1;
        end
    end

    // Array has no reset; contents survive reset. An in-flight access is aborted because
    // the asynchronous reset drops the state out of StWait before any later edge.
    always_ff @(posedge clock) begin
        if (do_access && acc_write && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata_al[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    write_d = req_write;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (LATENCY == 0) begin
                        state_d = StResp;
                        rdata_d = resp_data_next;
                        err_d   = acc_err;
                    end else begin
                        state_d = StWait;
                        cnt_d   = LatInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    rdata_d = resp_data_next;
                    err_d   = acc_err;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule
